// File: rtl/fifo_tx_pkg.sv
// Shared SpaceWire credit-flow definitions, used by both the TX and RX FIFOs.
package fifo_tx_pkg;

    typedef enum logic [1:0] {
        NO_CREDIT = 2'd0,
        CREDIT    = 2'd1,
        ERROR     = 2'd2
    } credit_state_t;

    localparam int CREDIT_MAX = 56;
    localparam int FCT_CREDIT = 8;
    localparam int FIFO_MAX   = 63;

endpackage

// File: rtl/fifo_tx_mem.sv
// Dual-port character store: synchronous write, asynchronous (show-ahead) read.
module mem_data_tx #(
    parameter int DWIDTH = 9,
    parameter int AWIDTH = 6
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic [DWIDTH-1:0] rd_data
);

    logic [DWIDTH-1:0] mem [2**AWIDTH];

    // NOTE: storage has no reset; pointers and the occupancy counter decide
    // which entries are meaningful, so a reset here would only cost logic.
    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_tx.sv
// SpaceWire TX FIFO: host-side character buffer gated by remote flow-control credit.
module fifo_tx
    import fifo_tx_pkg::*;
#(
    parameter int DWIDTH = 9,
    parameter int AWIDTH = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DWIDTH-1:0] data_in,
    input  logic              rd_en,
    input  logic              fct_in,
    input  logic              link_run,
    output logic [DWIDTH-1:0] data_out,
    output logic              f_full,
    output logic              f_empty,
    output logic [AWIDTH-1:0] counter,
    output logic [AWIDTH-1:0] credit_counter,
    output logic              tx_ready,
    output logic              overflow_credit_error
);

    credit_state_t     state, state_next;
    logic [AWIDTH-1:0] wr_ptr, rd_ptr;
    logic [AWIDTH-1:0] credit_next;
    logic [AWIDTH:0]   credit_sum;
    logic              push_acc, pop_acc, fct_overflow;

    mem_data_tx #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_mem (
        .clock   (clock),
        .wr_en   (push_acc),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_addr (rd_ptr),
        .rd_data (data_out)
    );

    assign f_full                = (counter == AWIDTH'(FIFO_MAX));
    assign f_empty               = (counter == '0);
    assign tx_ready              = (state == CREDIT) && !f_empty;
    assign overflow_credit_error = (state == ERROR);
    assign push_acc              = wr_en && !f_full;
    assign pop_acc               = rd_en && tx_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            counter <= '0;
        end else begin
            if (push_acc) wr_ptr <= wr_ptr + AWIDTH'(1);
            if (pop_acc)  rd_ptr <= rd_ptr + AWIDTH'(1);
            case ({push_acc, pop_acc})
                2'b10:   counter <= counter + AWIDTH'(1);
                2'b01:   counter <= counter - AWIDTH'(1);
                default: counter <= counter;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= NO_CREDIT;
            credit_counter <= '0;
        end else begin
            state          <= state_next;
            credit_counter <= credit_next;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        // One bit wider than the counter so 56 + 8 is seen as 64, not 0.
        credit_sum   = {1'b0, credit_counter} + (AWIDTH+1)'(FCT_CREDIT)
                     - {{AWIDTH{1'b0}}, pop_acc};
        fct_overflow = link_run && fct_in && (credit_sum > (AWIDTH+1)'(CREDIT_MAX));
        credit_next  = credit_counter;
        state_next   = state;

        if (!link_run)        credit_next = '0;
        else if (fct_in)      credit_next = fct_overflow ? credit_counter : credit_sum[AWIDTH-1:0];
        else if (pop_acc)     credit_next = credit_counter - AWIDTH'(1);

        if (!link_run) begin
            state_next = NO_CREDIT;
        end else if (fct_overflow) begin
            state_next = ERROR;
        end else begin
            case (state)
                NO_CREDIT: if (credit_next != '0) state_next = CREDIT;
                CREDIT:    if (credit_next == '0) state_next = NO_CREDIT;
                default:   state_next = state;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_tx.sv
// Scoreboard bench for fifo_tx: queue-based reference model, directed scenarios, then random traffic.
module tb_fifo_tx;

    logic       clock;
    logic       reset;
    logic       wr_en;
    logic [8:0] data_in;
    logic       rd_en;
    logic       fct_in;
    logic       link_run;
    logic [8:0] data_out;
    logic       f_full;
    logic       f_empty;
    logic [5:0] counter;
    logic [5:0] credit_counter;
    logic       tx_ready;
    logic       overflow_credit_error;

    fifo_tx dut (
        .clock                 (clock),
        .reset                 (reset),
        .wr_en                 (wr_en),
        .data_in               (data_in),
        .rd_en                 (rd_en),
        .fct_in                (fct_in),
        .link_run              (link_run),
        .data_out              (data_out),
        .f_full                (f_full),
        .f_empty               (f_empty),
        .counter               (counter),
        .credit_counter        (credit_counter),
        .tx_ready              (tx_ready),
        .overflow_credit_error (overflow_credit_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int         errors = 0;
    int         checks = 0;
    logic [8:0] m_q[$];    // reference FIFO contents
    logic [8:0] exp_q[$];  // scoreboard: characters expected to be popped
    int         m_credit = 0;
    bit         m_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        exp_q.delete();
        m_credit = 0;
        m_err    = 1'b0;
    endtask

    task automatic check_status();
        check("counter", 32'(counter), 32'(m_q.size()));
        check("credit_counter", 32'(credit_counter), 32'(m_credit));
        check("f_empty", 32'(f_empty), 32'(m_q.size() == 0));
        check("f_full", 32'(f_full), 32'(m_q.size() == 63));
        check("overflow_credit_error", 32'(overflow_credit_error), 32'(m_err));
        check("tx_ready", 32'(tx_ready), 32'(!m_err && m_credit > 0 && m_q.size() > 0));
        if (m_q.size() > 0) check("data_out", 32'(data_out), 32'(m_q[0]));
    endtask

    // One clock cycle of stimulus: drive on the falling edge, advance the model, check after the rising edge.
    task automatic cycle(input bit w, input logic [8:0] d, input bit r, input bit f, input bit l);
        bit m_ready, acc_push, acc_pop;
        int sum;
        @(negedge clock);
        wr_en = w; data_in = d; rd_en = r; fct_in = f; link_run = l;
        m_ready  = !m_err && m_credit > 0 && m_q.size() > 0;
        acc_push = w && m_q.size() < 63;
        acc_pop  = r && m_ready;
        if (acc_pop)  exp_q.push_back(m_q.pop_front());
        if (acc_push) m_q.push_back(d);
        if (!l) begin
            m_credit = 0;
            m_err    = 1'b0;
        end else if (f) begin
            sum = m_credit + 8 - int'(acc_pop);
            if (sum > 56) m_err = 1'b1;
            else          m_credit = sum;
        end else if (acc_pop) begin
            m_credit--;
        end
        @(posedge clock);
        #1;
        check_status();
    endtask

    task automatic idle();
        cycle(1'b0, 9'h0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clock);
        wr_en = 0; rd_en = 0; fct_in = 0; link_run = 1;
        reset = 1'b0;
        model_clear();
        @(negedge clock);
        reset = 1'b1;
    endtask

    // Monitor: compares every accepted pop against the scoreboard.
    initial begin
        forever begin
            @(negedge clock);
            #2;
            if (reset && rd_en && tx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected: got 0x%0h, expected no pop at %0t", data_out, $time);
                end else begin
                    check("pop_data", 32'(data_out), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        reset = 1'b0; wr_en = 0; data_in = '0; rd_en = 0; fct_in = 0; link_run = 0;
        #3;
        check("reset_f_empty", 32'(f_empty), 32'd1);
        check("reset_f_full", 32'(f_full), 32'd0);
        check("reset_tx_ready", 32'(tx_ready), 32'd0);
        check("reset_counter", 32'(counter), 32'd0);
        check("reset_credit", 32'(credit_counter), 32'd0);
        check("reset_error", 32'(overflow_credit_error), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // Three pushes without credit: nothing may leave.
        cycle(1, 9'h0AA, 0, 0, 1);
        cycle(1, 9'h0BB, 0, 0, 1);
        cycle(1, 9'h100, 0, 0, 1);
        check("pre_fct_tx_ready", 32'(tx_ready), 32'd0);
        check("pre_fct_counter", 32'(counter), 32'd3);
        check("pre_fct_data_out", 32'(data_out), 32'h0AA);

        // One FCT then three pops.
        cycle(0, 9'h0, 0, 1, 1);
        check("fct_credit", 32'(credit_counter), 32'd8);
        for (int i = 0; i < 3; i++) cycle(0, 9'h0, 1, 0, 1);
        check("after_pops_credit", 32'(credit_counter), 32'd5);
        check("after_pops_empty", 32'(f_empty), 32'd1);

        // Credit saturation and overflow error.
        cycle(0, 9'h0, 0, 0, 0);
        for (int i = 0; i < 7; i++) cycle(0, 9'h0, 0, 1, 1);
        check("credit_max", 32'(credit_counter), 32'd56);
        cycle(0, 9'h0, 0, 1, 1);
        check("overflow_credit_held", 32'(credit_counter), 32'd56);
        check("overflow_error_set", 32'(overflow_credit_error), 32'd1);
        idle();
        check("overflow_error_sticky", 32'(overflow_credit_error), 32'd1);
        cycle(0, 9'h0, 0, 0, 0);
        check("link_down_error", 32'(overflow_credit_error), 32'd0);
        check("link_down_credit", 32'(credit_counter), 32'd0);

        // Fill to capacity, reject the extra push, then drain through pointer wrap.
        for (int i = 0; i < 63; i++) cycle(1, 9'($urandom_range(0, 511)), 0, 0, 1);
        check("full_flag", 32'(f_full), 32'd1);
        cycle(1, 9'h1FF, 0, 0, 1);
        check("full_push_ignored", 32'(counter), 32'd63);
        for (int i = 0; i < 80 && m_q.size() > 0; i++) cycle(0, 9'h0, 1, m_credit <= 1, 1);
        check("drained_empty", 32'(f_empty), 32'd1);

        // Simultaneous push, pop and FCT with credit=1, counter=2.
        cycle(0, 9'h0, 0, 0, 0);
        for (int i = 0; i < 9; i++) cycle(1, 9'(i + 16), 0, 0, 1);
        cycle(0, 9'h0, 0, 1, 1);
        for (int i = 0; i < 7; i++) cycle(0, 9'h0, 1, 0, 1);
        check("setup_credit_1", 32'(credit_counter), 32'd1);
        check("setup_counter_2", 32'(counter), 32'd2);
        cycle(1, 9'h033, 1, 1, 1);
        check("simul_counter", 32'(counter), 32'd2);
        check("simul_credit", 32'(credit_counter), 32'd8);
        check("simul_tx_ready", 32'(tx_ready), 32'd1);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 9) < 6, 9'($urandom_range(0, 511)),
                  $urandom_range(0, 9) < 7, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 39) != 0);
        end

        // Asynchronous reset with counter=10, credit=20.
        do_reset();
        for (int i = 0; i < 14; i++) cycle(1, 9'(i + 100), 0, 0, 1);
        for (int i = 0; i < 3; i++) cycle(0, 9'h0, 0, 1, 1);
        for (int i = 0; i < 4; i++) cycle(0, 9'h0, 1, 0, 1);
        check("pre_reset_counter", 32'(counter), 32'd10);
        check("pre_reset_credit", 32'(credit_counter), 32'd20);
        @(negedge clock);
        wr_en = 0; rd_en = 0; fct_in = 0; link_run = 1;
        #1 reset = 1'b0;
        model_clear();
        #1;
        check("async_counter", 32'(counter), 32'd0);
        check("async_credit", 32'(credit_counter), 32'd0);
        check("async_f_empty", 32'(f_empty), 32'd1);
        check("async_f_full", 32'(f_full), 32'd0);
        check("async_tx_ready", 32'(tx_ready), 32'd0);
        check("async_error", 32'(overflow_credit_error), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        cycle(1, 9'h155, 0, 0, 1);
        check("post_reset_first", 32'(data_out), 32'h155);

        idle();
        idle();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
